// File: rtl/read_addr_decode_router_if.sv
// AR/R signal bundle around the read address decode router.
// The router connects through the slave modport; the surrounding fabric uses master.
interface read_addr_decode_router_if;
  logic [3:0]  ARID_ARB;
  logic [31:0] ARADDR_ARB;
  logic [3:0]  ARLEN_ARB;
  logic [2:0]  ARSIZE_ARB;
  logic [1:0]  ARBURST_ARB;
  logic        ARVALID_ARB;
  logic        M0_flag;
  logic        M1_flag;
  logic        ARREADY_ARB;

  logic [3:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic [2:0]  ARVALID_S;
  logic [2:0]  ARREADY_S;

  logic [11:0] RID_S;
  logic [95:0] RDATA_S;
  logic [5:0]  RRESP_S;
  logic [2:0]  RLAST_S;
  logic [2:0]  RVALID_S;
  logic [2:0]  RREADY_S;

  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M;
  logic        RVALID_M0;
  logic        RVALID_M1;
  logic        RREADY_M0;
  logic        RREADY_M1;
  logic        RVALID_ARB;
  logic        rlast_err;

  modport slave (
    input  ARID_ARB, ARADDR_ARB, ARLEN_ARB, ARSIZE_ARB, ARBURST_ARB, ARVALID_ARB,
    input  M0_flag, M1_flag,
    output ARREADY_ARB,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S,
    input  RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    output RREADY_S,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M0, RVALID_M1,
    input  RREADY_M0, RREADY_M1,
    output RVALID_ARB, rlast_err
  );

  modport master (
    output ARID_ARB, ARADDR_ARB, ARLEN_ARB, ARSIZE_ARB, ARBURST_ARB, ARVALID_ARB,
    output M0_flag, M1_flag,
    input  ARREADY_ARB,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S,
    output RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S,
    input  RREADY_S,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M0, RVALID_M1,
    output RREADY_M0, RREADY_M1,
    input  RVALID_ARB, rlast_err
  );
endinterface

// File: rtl/read_addr_decode_router.sv
// Decodes the arbitrated read address to one of three slaves or a DECERR default slave,
// issues the AR, then routes the selected R channel back to the requesting master.
//
// state | meaning
// IDLE  | ready for a new arbitrated request
// ADDR  | ARVALID held to the selected slave until ARREADY
// DATA  | slave R channel routed to the requesting master
// DERR  | internal default slave returns len+1 DECERR beats
module read_addr_decode_router #(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S1_BASE  = 32'h0001_0000,
  parameter logic [31:0] S2_BASE  = 32'h0002_0000,
  parameter int          WIN_BITS = 16
) (
  input logic                       ACLK,
  input logic                       ARESET,
  read_addr_decode_router_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DERR} state_t;

  state_t      state;
  logic [1:0]  sel;
  logic        mst;
  logic [3:0]  beat;
  logic [2:0]  arvalid;
  logic        rlast_err;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;

  logic        hit0, hit1, hit2;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, s_rvalid;
  logic        in_data, in_derr, rvalid_act, rready_act, r_hs, at_max;

  assign hit0 = (bus.ARADDR_ARB >> WIN_BITS) == (S0_BASE >> WIN_BITS);
  assign hit1 = (bus.ARADDR_ARB >> WIN_BITS) == (S1_BASE >> WIN_BITS);
  assign hit2 = (bus.ARADDR_ARB >> WIN_BITS) == (S2_BASE >> WIN_BITS);

  always_comb begin
    s_rid    = bus.RID_S[3:0];
    s_rdata  = bus.RDATA_S[31:0];
    s_rresp  = bus.RRESP_S[1:0];
    s_rlast  = bus.RLAST_S[0];
    s_rvalid = bus.RVALID_S[0];
    case (sel)
      2'd1: begin
        s_rid    = bus.RID_S[7:4];
        s_rdata  = bus.RDATA_S[63:32];
        s_rresp  = bus.RRESP_S[3:2];
        s_rlast  = bus.RLAST_S[1];
        s_rvalid = bus.RVALID_S[1];
      end
      2'd2: begin
        s_rid    = bus.RID_S[11:8];
        s_rdata  = bus.RDATA_S[95:64];
        s_rresp  = bus.RRESP_S[5:4];
        s_rlast  = bus.RLAST_S[2];
        s_rvalid = bus.RVALID_S[2];
      end
      default: ;
    endcase
  end

  assign in_data    = (state == DATA);
  assign in_derr    = (state == DERR);
  assign rvalid_act = (in_data & s_rvalid) | in_derr;
  assign rready_act = mst ? bus.RREADY_M1 : bus.RREADY_M0;
  assign r_hs       = rvalid_act & rready_act;
  assign at_max     = (beat == ar_len);

  assign bus.ARREADY_ARB = (state == IDLE) & ~ARESET;

  assign bus.ARID_S    = ar_id;
  assign bus.ARADDR_S  = ar_addr;
  assign bus.ARLEN_S   = ar_len;
  assign bus.ARSIZE_S  = ar_size;
  assign bus.ARBURST_S = ar_burst;
  assign bus.ARVALID_S = arvalid;

  assign bus.RREADY_S   = in_data ? (3'(rready_act) << sel) : 3'b000;
  assign bus.RVALID_M0  = rvalid_act & ~mst;
  assign bus.RVALID_M1  = rvalid_act & mst;
  assign bus.RVALID_ARB = rvalid_act;
  assign bus.RID_M      = in_data ? s_rid : (in_derr ? ar_id : 4'h0);
  assign bus.RDATA_M    = in_data ? s_rdata : 32'h0;
  assign bus.RRESP_M    = in_data ? s_rresp : (in_derr ? 2'b11 : 2'b00);
  assign bus.RLAST_M    = in_data ? s_rlast : (in_derr & at_max);
  assign bus.rlast_err  = rlast_err;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= IDLE;
      sel       <= 2'd0;
      mst       <= 1'b0;
      beat      <= 4'd0;
      arvalid   <= 3'b000;
      rlast_err <= 1'b0;
      ar_id     <= 4'h0;
      ar_addr   <= 32'h0;
      ar_len    <= 4'h0;
      ar_size   <= 3'h0;
      ar_burst  <= 2'h0;
    end else begin
      case (state)
        IDLE: if (bus.ARVALID_ARB) begin
          ar_id    <= bus.ARID_ARB;
          ar_addr  <= bus.ARADDR_ARB;
          ar_len   <= bus.ARLEN_ARB;
          ar_size  <= bus.ARSIZE_ARB;
          ar_burst <= bus.ARBURST_ARB;
          beat     <= 4'd0;
          // conflicting or absent master flags fall back to M0
          mst      <= bus.M1_flag & ~bus.M0_flag;
          if (hit0) begin
            sel <= 2'd0; arvalid <= 3'b001; state <= ADDR;
          end else if (hit1) begin
            sel <= 2'd1; arvalid <= 3'b010; state <= ADDR;
          end else if (hit2) begin
            sel <= 2'd2; arvalid <= 3'b100; state <= ADDR;
          end else begin
            sel <= 2'd0; state <= DERR;
          end
        end
        ADDR: if (|(arvalid & bus.ARREADY_S)) begin
          arvalid <= 3'b000;
          state   <= DATA;
        end
        DATA: if (r_hs) begin
          // burst closes on whichever of slave RLAST or the beat count comes first
          if (s_rlast | at_max) begin
            if (s_rlast ^ at_max) rlast_err <= 1'b1;
            beat  <= 4'd0;
            state <= IDLE;
          end else begin
            beat <= beat + 4'd1;
          end
        end
        DERR: if (r_hs) begin
          if (at_max) begin
            beat  <= 4'd0;
            state <= IDLE;
          end else begin
            beat <= beat + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_addr_decode_router.sv
// Bench for read_addr_decode_router: request driver plus slave models feed a scoreboard
// whose expectations come from a window-division address model.
module tb_read_addr_decode_router;
  localparam logic [31:0] S0B = 32'h0000_0000;
  localparam logic [31:0] S1B = 32'h0001_0000;
  localparam logic [31:0] S2B = 32'h0002_0000;

  typedef struct { bit mst; logic [3:0] id; logic [31:0] data; logic [1:0] resp; bit last; } rexp_t;
  typedef struct { int s; logic [3:0] id; logic [31:0] addr; logic [3:0] len; logic [2:0] size; logic [1:0] burst; } arexp_t;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  read_addr_decode_router_if bus ();
  read_addr_decode_router #(.S0_BASE(S0B), .S1_BASE(S1B), .S2_BASE(S2B), .WIN_BITS(16))
    dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

  int vectors = 0, miscompares = 0, cyc = 0;
  int own = -1, accept_cyc = 0, done_cyc = 0;
  bit mon_en = 1'b0, exp_err = 1'b0;
  rexp_t exp_q[$];
  arexp_t ar_q[$];
  rexp_t e;
  arexp_t a;
  logic        o_valid = 1'b0, o_last = 1'b0;
  logic [31:0] o_data = '0;
  logic [3:0]  o_id = '0;
  logic [1:0]  o_resp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int model_decode(input logic [31:0] addr);
    if (addr / 32'h1_0000 == S0B / 32'h1_0000) return 0;
    if (addr / 32'h1_0000 == S1B / 32'h1_0000) return 1;
    if (addr / 32'h1_0000 == S2B / 32'h1_0000) return 2;
    return -1;
  endfunction

  always @(posedge ACLK) cyc++;

  // single driver of slave R inputs and master RREADY; unowned slaves chatter randomly
  always @(posedge ACLK) begin
    #2;
    for (int i = 0; i < 3; i++) begin
      if (i == own) begin
        bus.RVALID_S[i] = o_valid;
        bus.RLAST_S[i]  = o_last;
        bus.RDATA_S[i*32 +: 32] = o_data;
        bus.RID_S[i*4 +: 4]     = o_id;
        bus.RRESP_S[i*2 +: 2]   = o_resp;
      end else begin
        bus.RVALID_S[i] = 1'($urandom_range(0, 1));
        bus.RLAST_S[i]  = 1'($urandom_range(0, 1));
        bus.RDATA_S[i*32 +: 32] = $urandom;
        bus.RID_S[i*4 +: 4]     = 4'($urandom_range(0, 15));
        bus.RRESP_S[i*2 +: 2]   = 2'($urandom_range(0, 3));
      end
    end
    bus.RREADY_M0 = ($urandom_range(0, 3) != 0);
    bus.RREADY_M1 = ($urandom_range(0, 3) != 0);
  end

  // scoreboard monitor
  always @(negedge ACLK) begin
    if (mon_en) begin
      if (bus.RVALID_M0 || bus.RVALID_M1) begin
        if (exp_q.size() == 0) chk("r_spurious", {bus.RVALID_M1, bus.RVALID_M0}, 0);
        else begin
          e = exp_q[0];
          chk("r_master", {bus.RVALID_M1, bus.RVALID_M0}, e.mst ? 2'b10 : 2'b01);
          chk("r_data", bus.RDATA_M, e.data);
          chk("r_id", bus.RID_M, e.id);
          chk("r_resp", bus.RRESP_M, e.resp);
          chk("r_last", bus.RLAST_M, e.last);
          chk("rvalid_arb", bus.RVALID_ARB, 1);
          if (e.mst ? bus.RREADY_M1 : bus.RREADY_M0) void'(exp_q.pop_front());
        end
      end
      if (bus.ARVALID_S != 3'b000) begin
        if (ar_q.size() == 0) chk("ar_spurious", bus.ARVALID_S, 0);
        else begin
          a = ar_q[0];
          chk("ar_sel", bus.ARVALID_S, 3'b001 << a.s);
          chk("ar_addr", bus.ARADDR_S, a.addr);
          chk("ar_id", bus.ARID_S, a.id);
          chk("ar_len", bus.ARLEN_S, a.len);
          chk("ar_size_burst", {bus.ARSIZE_S, bus.ARBURST_S}, {a.size, a.burst});
          if (|(bus.ARVALID_S & bus.ARREADY_S)) void'(ar_q.pop_front());
        end
      end
      if ((bus.RREADY_S & ~((own >= 0) ? (3'b001 << own) : 3'b000)) != 3'b000)
        chk("rready_s_other", bus.RREADY_S, 0);
    end
  end

  // one read: called at a negedge, returns at a negedge with the DUT idle
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input bit f0, input bit f1, input int last_at, input int ar_dly,
                         input int abort_after);
    int s, n, hs, budget, lastb;
    bit mst;
    logic [2:0] size;
    logic [1:0] burst;
    logic [31:0] dat [16];
    logic [1:0]  rsp [16];
    s     = model_decode(addr);
    mst   = f1 && !f0;
    size  = 3'($urandom_range(0, 2));
    burst = 2'($urandom_range(0, 2));
    lastb = (s < 0) ? int'(len) : ((last_at < int'(len)) ? last_at : int'(len));
    n     = lastb + 1;
    for (int b = 0; b < n; b++) begin
      dat[b] = (s < 0) ? 32'h0 : $urandom;
      rsp[b] = (s < 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (abort_after < 0 || b < abort_after)
        exp_q.push_back('{mst, id, dat[b], rsp[b], (s < 0) ? (b == int'(len)) : (b == last_at)});
    end
    if (s >= 0 && abort_after < 0 && last_at != int'(len)) exp_err = 1'b1;
    if (s >= 0) ar_q.push_back('{s, id, addr, len, size, burst});

    bus.ARID_ARB = id; bus.ARADDR_ARB = addr; bus.ARLEN_ARB = len;
    bus.ARSIZE_ARB = size; bus.ARBURST_ARB = burst;
    bus.M0_flag = f0; bus.M1_flag = f1; bus.ARVALID_ARB = 1'b1;
    budget = 0;
    while (!bus.ARREADY_ARB && budget < 50) begin @(negedge ACLK); budget++; end
    chk("accept", bus.ARREADY_ARB, 1);
    @(posedge ACLK); #1;
    accept_cyc = cyc;
    bus.ARVALID_ARB = 1'b0;
    bus.ARADDR_ARB = $urandom;
    @(negedge ACLK);
    chk("arvalid_lat", bus.ARVALID_S, (s < 0) ? 3'b000 : (3'b001 << s));

    if (s < 0) begin
      hs = 0; budget = 0;
      while (hs < n && budget < 200) begin
        if (mst ? (bus.RVALID_M1 && bus.RREADY_M1) : (bus.RVALID_M0 && bus.RREADY_M0)) hs++;
        if (hs < n) begin @(negedge ACLK); budget++; end
      end
      chk("derr_beats", hs, n);
      @(posedge ACLK); #1;
    end else begin
      own = s; o_valid = 1'b0; o_last = 1'b0;
      for (int k = 0; k < ar_dly; k++) begin
        bus.ARVALID_ARB = 1'b1;
        chk("busy_refuse", bus.ARREADY_ARB, 0);
        @(negedge ACLK);
      end
      bus.ARVALID_ARB = 1'b0;
      bus.ARREADY_S[s] = 1'b1;
      @(posedge ACLK); #1;
      bus.ARREADY_S[s] = 1'b0;
      for (int b = 0; b < n; b++) begin
        if (b == abort_after) begin
          ARESET = 1'b1;
          @(posedge ACLK); #1;
          ARESET = 1'b0;
          exp_err = 1'b0;
          @(negedge ACLK);
          chk("abort_err", bus.rlast_err, 0);
          chk("abort_idle", bus.ARREADY_ARB, 1);
          chk("abort_valids", {bus.RVALID_M0, bus.RVALID_M1, bus.RVALID_ARB, bus.ARVALID_S}, 0);
          own = -1;
          return;
        end
        repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
        o_id = id; o_data = dat[b]; o_resp = rsp[b]; o_last = (b == last_at); o_valid = 1'b1;
        budget = 0;
        do begin @(negedge ACLK); budget++; end while (!bus.RREADY_S[s] && budget < 100);
        chk("beat_ready", bus.RREADY_S[s], 1);
        @(posedge ACLK); #1;
        o_valid = 1'b0; o_last = 1'b0;
      end
    end
    done_cyc = cyc;
    @(negedge ACLK);
    own = -1;
    chk("arready_after", bus.ARREADY_ARB, 1);
    chk("rlast_err", bus.rlast_err, exp_err);
    chk("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    int d1, len, last_at;
    logic [31:0] addr;
    bus.ARVALID_ARB = 1'b0; bus.ARID_ARB = '0; bus.ARADDR_ARB = '0; bus.ARLEN_ARB = '0;
    bus.ARSIZE_ARB = '0; bus.ARBURST_ARB = '0; bus.M0_flag = 1'b0; bus.M1_flag = 1'b0;
    bus.ARREADY_S = 3'b000;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_arready", bus.ARREADY_ARB, 0);
    chk("rst_arvalid", bus.ARVALID_S, 0);
    chk("rst_rvalid", {bus.RVALID_M0, bus.RVALID_M1, bus.RVALID_ARB, bus.RREADY_S}, 0);
    chk("rst_err", bus.rlast_err, 0);
    chk("rst_payload", {bus.ARADDR_S, bus.RDATA_M}, 0);
    ARESET = 1'b0;
    #1;
    chk("rst_release", bus.ARREADY_ARB, 1);
    mon_en = 1'b1;

    do_read(4'h3, 32'h0001_0040, 4'd0, 1'b1, 1'b0, 0, 0, -1);
    do_read(4'h5, 32'h0002_0000, 4'd3, 1'b0, 1'b1, 3, 1, -1);
    do_read(4'h7, 32'h0004_0000, 4'd1, 1'b1, 1'b0, 1, 0, -1);
    do_read(4'h2, 32'h0000_1234, 4'd2, 1'b1, 1'b0, 2, 3, -1);
    do_read(4'h1, 32'h0000_0010, 4'd1, 1'b1, 1'b0, 1, 0, -1);
    d1 = done_cyc;
    do_read(4'h9, 32'h0002_0100, 4'd0, 1'b0, 1'b1, 0, 0, -1);
    chk("b2b_accept", accept_cyc - d1, 1);
    do_read(4'h4, 32'h0001_0000, 4'd3, 1'b1, 1'b0, 2, 0, -1);
    do_read(4'h6, 32'h0001_0080, 4'd3, 1'b0, 1'b1, 3, 0, 2);
    do_read(4'hA, 32'h0000_FFFF, 4'd0, 1'b1, 1'b1, 0, 1, -1);
    do_read(4'hB, 32'h0003_0000, 4'd15, 1'b0, 1'b1, 15, 0, -1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 5))
        0: addr = S0B + $urandom_range(0, 32'hFFFF);
        1: addr = S1B + $urandom_range(0, 32'hFFFF);
        2: addr = S2B + $urandom_range(0, 32'hFFFF);
        3: addr = ($urandom_range(0, 1) != 0) ? S2B + 32'hFFFF : S2B + 32'h1_0000;
        4: addr = $urandom;
        default: addr = 32'h0003_0000 + $urandom_range(0, 32'hFFFF);
      endcase
      len = $urandom_range(0, 15);
      last_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 16)) : len;
      do_read(4'($urandom_range(0, 15)), addr, 4'(len), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), last_at, $urandom_range(0, 3), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish by %0t, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/read_addr_decode_router.md
Name: read_addr_decode_router

Overview:
- Sits directly downstream of the read address arbiter.
- Accepts the arbitrated AR request together with its master flags and decodes the address to one of three slaves, or to an internal default slave.
- Issues the AR to the selected slave, then routes that slave's R channel back to the originating master until the burst completes.
- One outstanding read transaction at a time.

Parameters:
- S0_BASE, 32'h0000_0000, base of slave 0 (ROM) window
- S1_BASE, 32'h0001_0000, base of slave 1 (IM) window
- S2_BASE, 32'h0002_0000, base of slave 2 (DM) window
- WIN_BITS, 16, window size = 2**WIN_BITS bytes; a hit requires ARADDR[31:WIN_BITS] == BASE[31:WIN_BITS]

Ports:
- ACLK in 1 clock
- ARESET in 1 synchronous active-high reset
- ARID_ARB/ARADDR_ARB/ARLEN_ARB/ARSIZE_ARB/ARBURST_ARB in 4/32/4/3/2 arbitrated AR fields
- ARVALID_ARB in 1 arbitrated AR valid
- M0_flag, M1_flag in 1 each, requesting master from the arbiter
- ARREADY_ARB out 1 accept to arbiter
- ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S out 4/32/4/3/2, registered AR fields shared by all slaves
- ARVALID_S out 3 one-hot per slave
- ARREADY_S in 3 per slave
- RID_S in 12 ({S2,S1,S0} x 4)
- RDATA_S in 96
- RRESP_S in 6
- RLAST_S in 3
- RVALID_S in 3
- RREADY_S out 3
- RID_M out 4, RDATA_M out 32, RRESP_M out 2, RLAST_M out 1: shared R payload to both masters
- RVALID_M0, RVALID_M1 out 1 each
- RREADY_M0, RREADY_M1 in 1 each
- RVALID_ARB out 1: RVALID of the active transaction, fed back to the arbiter
- rlast_err out 1: sticky flag, slave RLAST disagreed with the beat count

Behaviour:
- Reset: state=IDLE. All ARVALID_S, RREADY_S, RVALID_M0/M1, RVALID_ARB, rlast_err = 0. All AR and R payload outputs = 0. Beat counter = 0.
- ARREADY_ARB = (state==IDLE) & ~ARESET. The accept is combinational on state only, with no dependency on ARVALID_ARB.
- IDLE:
  - On ARVALID_ARB, capture fields, beat_max = ARLEN_ARB, and mst = (M1_flag & ~M0_flag). Both flags 0 or both 1 selects M0.
  - Decode in priority order S0, S1, S2. No hit selects the default slave.
  - Next state is ADDR for a slave hit, DERR for no hit.
- ADDR:
  - ARVALID_S[sel] = 1; AR fields driven from the captured registers.
  - On ARREADY_S[sel], next state is DATA.
  - ARVALID_S stays asserted until the handshake; fields are stable throughout.
- DATA:
  - RDATA_M/RID_M/RRESP_M/RLAST_M = slave[sel] R signals (combinational).
  - RVALID_M[mst] = RVALID_S[sel]; the other master's RVALID = 0.
  - RREADY_S[sel] = RREADY_M[mst]; other RREADY_S = 0.
  - RVALID_ARB = RVALID_S[sel].
  - Each RVALID&RREADY handshake increments the beat counter.
  - The burst ends on the handshake where RLAST_S[sel]=1 or beat==beat_max, whichever comes first. Next state is IDLE and the counter clears.
  - If RLAST and (beat==beat_max) differ on that beat, rlast_err <= 1. It is sticky until reset.
- DERR (default slave):
  - RVALID_M[mst] = 1, RDATA_M = 0, RRESP_M = 2'b11 (DECERR), RID_M = captured ID, RLAST_M = (beat==beat_max). RVALID_ARB = 1.
  - Produces beat_max+1 beats, each advancing on RREADY_M[mst].
  - Returns to IDLE after the last handshake. No slave sees ARVALID.
- RVALID is never withdrawn by the default slave before its handshake. Payload stays stable while RVALID=1 and RREADY=0.
- Latency:
  - ARVALID_ARB accept → ARVALID_S high: 1 cycle.
  - Last R handshake → ARREADY_ARB high: 1 cycle.
  - Minimum single-beat transaction: IDLE, ADDR, DATA = 3 cycles.
- Requests presented in any state other than IDLE are not accepted, because ARREADY_ARB=0.
- Beat counter is 4 bits and never wraps: maximum ARLEN=15 gives 16 beats.
- ARESET asserted mid-transaction: next edge forces IDLE, drops all valids/readies, and clears rlast_err. The slave side is not drained.
- R signals from non-selected slaves are ignored; their RREADY_S stays 0.

Test Plan:
- M0 read, ARADDR=0x0001_0040, ARLEN=0:
  - ARVALID_S=3'b010 one cycle after accept.
  - Slave returns RDATA=0xDEAD_BEEF with RLAST=1, giving RVALID_M0=1 and RDATA_M=0xDEAD_BEEF.
  - ARREADY_ARB returns high on the next cycle.
- M1 flag, ARADDR=0x0002_0000, ARLEN=3, RREADY_M1 low 2 cycles on beat 1:
  - 4 beats delivered to M1 only; payload is held during the stall.
  - RVALID_M0 stays 0 throughout.
- ARADDR=0x0004_0000, ARLEN=1 from M0:
  - No ARVALID_S asserted.
  - 2 beats with RRESP_M=2'b11 and RDATA_M=0; RLAST_M on beat 2 only.
- S0 ARREADY delayed 3 cycles:
  - ARVALID_S[0] held 3 cycles with constant ARADDR_S.
  - A new ARVALID_ARB during this time sees ARREADY_ARB=0.
- Two back-to-back reads (M0 to S0, then M1 to S2):
  - Second accept occurs exactly 1 cycle after the first burst's RLAST handshake.
  - RID_M of the second read equals its ARID.
- ARLEN=3 while the slave asserts RLAST on beat 2:
  - Transaction ends and rlast_err=1.
  - ARESET for 1 cycle mid-burst returns state to IDLE and gives rlast_err=0.
